anu_lsu: RTL and testbench
==========================

# anu_lsu

Parametrised load/store unit that replaces the core's single-cycle, always-ready data-memory path with a handshaked, multi-cycle interface. It sits between the execute stage and data memory. It takes one load or store request per instruction and generates byte enables and lane-steered write data. It waits on memory with `valid`/`ready`/`rvalid`, stalls the core until completion, and returns sign- or zero-extended load data. It also reports misalignment and timeout faults.

## Interface
Parameters:
- `XLEN`, 32: data/address width; 32 or 64.
- `TIMEOUT`, 16: max wait cycles per memory phase; 0 disables timeout.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage has a memory instruction; held until `rsp_valid`.
- `req_we` in 1: 1 store, 0 load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- `req_unsigned` in 1: zero-extend load data.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `stall` out 1: freeze PC/writeback.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: qualifies `rsp_valid`; misaligned or timeout.
- `mem_valid` out 1: request to memory.
- `mem_ready` in 1: memory accepts request.
- `mem_we` out 1: write strobe.
- `mem_addr` out XLEN: address aligned down to XLEN/8.
- `mem_be` out XLEN/8: byte enables.
- `mem_wdata` out XLEN: lane-replicated store data.
- `mem_rvalid` in 1: load data valid.
- `mem_rdata` in XLEN: full-width read word.

## Operation
- The unit has four states: IDLE, REQ, RWAIT, DONE.
- **IDLE**
  - On `req_valid`, latch the request and go to REQ.
  - If the request is faulting and ANU_LSU_MISALIGN_EN is compiled in, go straight to DONE with the fault flag set.
- **REQ**
  - Drive `mem_valid` with stable `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` until `mem_ready`.
  - On `mem_ready` for a store, go to DONE.
  - On `mem_ready` for a load, go to RWAIT.
- **RWAIT**
  - On `mem_rvalid`, capture the steered and extended data, then go to DONE.
  - `mem_rvalid` is ignored in every other state.
- **DONE**
  - Assert `rsp_valid` for one cycle, then go to IDLE.
  - `req_valid` seen in DONE belongs to the completing instruction and is ignored.
- **Stall:** `stall = req_valid & ~rsp_valid`. This is combinational, so the core stalls from the first cycle of a request.
- **Byte enables:** `mem_be` covers `1<<req_size` bytes, shifted by `addr[log2(XLEN/8)-1:0]`.
- **Write data:** the byte, half or word is replicated across all lanes.
- **Load extraction:** shift right by `offset*8`, mask to size, then sign-extend from the top bit unless `req_unsigned`.
- **Size 11 with XLEN=32:** treated as misaligned.
- **Timeout**
  - A counter resets on entering REQ or RWAIT.
  - When `TIMEOUT!=0` and the count reaches `TIMEOUT` without a handshake, go to DONE with `rsp_fault=1` and `rsp_rdata=0`.
  - `mem_valid` drops in that same transition.

## Timing
- **Reset values:** state IDLE, all outputs 0, counter 0. Reset mid-transaction abandons it; a late `mem_rvalid` arriving in IDLE is ignored.
- **Zero-wait store:** `req_valid`@0 (IDLE), REQ@1 with `mem_ready`=1, DONE@2 with `rsp_valid`. Total 3 cycles with `stall` high for cycles 0–1.
- **Zero-wait load:** REQ@1 `mem_ready`, RWAIT@2 `mem_rvalid`, DONE@3.
- **Held memory request:** `mem_valid` never drops before `mem_ready` except on timeout.
- **Data stability:** `rsp_rdata` is registered and valid only while `rsp_valid`.

## Configuration
- `ANU_LSU_MISALIGN_EN` defined:
  - Accesses where `addr % (1<<size) != 0` complete in DONE one cycle after IDLE, with `rsp_fault=1` and no memory transaction.
- Not defined:
  - Low address bits below the access size are forced to 0, so the access is naturally aligned.
  - No misalignment fault is raised; only timeout can fault.

## Structure
- **Package `anu_lsu_pkg`:** holds the size encoding constants (SZ_B/SZ_H/SZ_W/SZ_D), the state enum, and the `be_gen(size, offset)` function.
- **Sub-module `anu_lsu_align`:** combinational store lane replication and load extract/extend, parametrised on XLEN.
- **Top level:** contains the FSM and the timeout counter.

## Test plan
- **Store byte, XLEN=32:** addr 0x1003, wdata 0xAB → `mem_be`=1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x1000, `rsp_valid` at cycle 2.
- **Load half, signed then unsigned:** addr 0x2002, `mem_rdata`=0x8001_1234 → signed gives 0xFFFF8001; `req_unsigned`=1 gives 0x00008001.
- **Memory backpressure:** `mem_ready` low for 5 cycles, then `rvalid` after 3 more → `mem_valid` stays stable, `stall` high throughout, `rsp_valid` exactly once.
- **Timeout:** `TIMEOUT`=4 and `mem_ready` never asserted → `rsp_fault`=1, `rsp_rdata`=0, `mem_valid` low after 4 REQ cycles.
- **Misaligned word at 0x3002:** with ANU_LSU_MISALIGN_EN → fault, no `mem_valid`; without it → `mem_addr` 0x3000, `mem_be` 1111.
- **Reset and XLEN=64:** `rst_n` low during RWAIT → all outputs 0, and a stray `mem_rvalid` next cycle produces no `rsp_valid`. With XLEN=64, a double load at 0x8 returns the full 64-bit word.

Source files
------------

// File: rtl/anu_lsu_pkg.sv
// Shared definitions for the anu_lsu load/store unit: access size encodings,
// FSM state type, latched request control payload and byte-enable helper.
package anu_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

    // Control fields of an accepted request, held until completion.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [2:0] off;
    } lsu_ctl_t;

    // (1<<size) contiguous byte lanes starting at byte offset; sized for XLEN=64,
    // callers truncate to their lane count.
    function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [2:0] offset);
        logic [15:0] m;
        m = (16'd1 << (5'd1 << size)) - 16'd1;
        return 8'(m << offset);
    endfunction

    // Address bits below the access size.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

endpackage

// File: rtl/anu_lsu_align.sv
// Lane steering for anu_lsu: store data replicated across every lane of the
// memory word, and load data shifted down, masked and sign/zero-extended.
// Ports:
//   st_size, st_data      -> st_lanes_c   store replication
//   ld_size, ld_unsigned,
//   ld_off, ld_raw        -> ld_data_c    load extract/extend
module anu_lsu_align
    import anu_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      st_size,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] st_lanes_c,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [2:0]      ld_off,
    input  logic [XLEN-1:0] ld_raw,
    output logic [XLEN-1:0] ld_data_c
);

    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] ld_sh;

    // Store: replicate the right-aligned datum into every lane it could occupy.
    always_comb begin
        st_lanes_c = st_data;
        case (st_size)
            SZ_B:    st_lanes_c = {NB{st_data[7:0]}};
            SZ_H:    st_lanes_c = {(NB / 2){st_data[15:0]}};
            SZ_W:    st_lanes_c = {(NB / 4){st_data[31:0]}};
            default: st_lanes_c = st_data;
        endcase
    end

    // Load: bring the addressed bytes to bit 0, then extend from the datum's top bit.
    always_comb begin
        ld_sh     = ld_raw >> {ld_off, 3'b000};
        ld_data_c = ld_sh;
        case (ld_size)
            SZ_B: begin
                if (ld_unsigned) ld_data_c = XLEN'(ld_sh[7:0]);
                else             ld_data_c = XLEN'($signed(ld_sh[7:0]));
            end
            SZ_H: begin
                if (ld_unsigned) ld_data_c = XLEN'(ld_sh[15:0]);
                else             ld_data_c = XLEN'($signed(ld_sh[15:0]));
            end
            SZ_W: begin
                if (ld_unsigned) ld_data_c = XLEN'(ld_sh[31:0]);
                else             ld_data_c = XLEN'($signed(ld_sh[31:0]));
            end
            default: ld_data_c = ld_sh;
        endcase
    end

endmodule

// File: rtl/anu_lsu.sv
// Handshaked load/store unit between the execute stage and data memory.
// Accepts one request per instruction, drives a held valid/ready request to
// memory, waits for read data on loads, and returns a one-cycle response with
// extended load data or a fault (timeout, or misalignment when built with
// ANU_LSU_MISALIGN_EN; otherwise misaligned addresses are aligned down).
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   req_valid/we/size/unsigned/addr/wdata    execute-stage request
//   stall                                    combinational core stall
//   rsp_valid/rdata/fault                    completion pulse and result
//   mem_valid/ready/we/addr/be/wdata         memory request channel
//   mem_rvalid/rdata                         memory read-data channel
module anu_lsu
    import anu_lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned NB      = XLEN / 8;
    localparam int unsigned OFFW    = $clog2(NB);
    localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    lsu_state_e      state_q, state_nx;
    lsu_ctl_t        ctl_q;
    logic [CW-1:0]   cnt_q;

    logic [1:0]      eff_size_c;
    logic [2:0]      raw_off_c, al_off_c, smask_c;
    logic            misaligned_c;
    logic            timeout_hit_c;
    logic            accept_c, cnt_clr_c, cnt_inc_c, fault_nx_c;
    logic [XLEN-1:0] st_lanes_c, ld_data_c;

    assign stall = req_valid & ~rsp_valid;

    // Request decode: a double on a 32-bit datapath degrades to a word.
    always_comb begin
        eff_size_c = req_size;
        if (XLEN == 32 && req_size == SZ_D) eff_size_c = SZ_W;
        raw_off_c = 3'(req_addr[OFFW-1:0]);
        smask_c   = size_mask(eff_size_c);
        al_off_c  = raw_off_c & ~smask_c;
    end

`ifdef ANU_LSU_MISALIGN_EN
    assign misaligned_c = (|(raw_off_c & smask_c)) || (XLEN == 32 && req_size == SZ_D);
`else
    assign misaligned_c = 1'b0;
`endif

    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CW'(TO_LAST));

    anu_lsu_align #(.XLEN(XLEN)) u_align (
        .st_size     (eff_size_c),
        .st_data     (req_wdata),
        .st_lanes_c  (st_lanes_c),
        .ld_size     (ctl_q.size),
        .ld_unsigned (ctl_q.uns),
        .ld_off      (ctl_q.off),
        .ld_raw      (mem_rdata),
        .ld_data_c   (ld_data_c)
    );

    // Next-state and control decode.
    always_comb begin
        state_nx   = state_q;
        accept_c   = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        fault_nx_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_c  = 1'b1;
                    cnt_clr_c = 1'b1;
                    if (misaligned_c) begin
                        state_nx   = ST_DONE;
                        fault_nx_c = 1'b1;
                    end else begin
                        state_nx = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    cnt_clr_c = 1'b1;
                    state_nx  = ctl_q.we ? ST_DONE : ST_RWAIT;
                end else if (timeout_hit_c) begin
                    state_nx   = ST_DONE;
                    fault_nx_c = 1'b1;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            ST_RWAIT: begin
                if (mem_rvalid) begin
                    state_nx = ST_DONE;
                end else if (timeout_hit_c) begin
                    state_nx   = ST_DONE;
                    fault_nx_c = 1'b1;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State, wait counter and latched request control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_nx;
            if (cnt_clr_c)                      cnt_q <= '0;
            else if (cnt_inc_c && TIMEOUT != 0) cnt_q <= cnt_q + CW'(1);
            if (accept_c) begin
                ctl_q.we   <= req_we;
                ctl_q.size <= eff_size_c;
                ctl_q.uns  <= req_unsigned;
                ctl_q.off  <= al_off_c;
            end
        end
    end

    // Registered outputs, loaded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            mem_valid <= (state_nx == ST_REQ);
            if (accept_c) begin
                mem_we    <= req_we;
                mem_addr  <= {req_addr[XLEN-1:OFFW], OFFW'(0)};
                mem_be    <= NB'(be_gen(eff_size_c, al_off_c));
                mem_wdata <= st_lanes_c;
            end
            rsp_valid <= (state_nx == ST_DONE);
            rsp_fault <= fault_nx_c;
            rsp_rdata <= (state_q == ST_RWAIT && mem_rvalid) ? ld_data_c : '0;
        end
    end

endmodule

// File: tb/tb_anu_lsu.sv
// Scoreboard bench for anu_lsu: a 32-bit instance (TIMEOUT 16) and a 64-bit
// instance (TIMEOUT 4) share stimulus; sel picks which one is active.
module tb_anu_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;

    logic        s32_stall, s32_rsp_valid, s32_rsp_fault, s32_mem_valid, s32_mem_we;
    logic [31:0] s32_rsp_rdata, s32_mem_addr, s32_mem_wdata;
    logic [3:0]  s32_mem_be;
    logic        s64_stall, s64_rsp_valid, s64_rsp_fault, s64_mem_valid, s64_mem_we;
    logic [63:0] s64_rsp_rdata, s64_mem_addr, s64_mem_wdata;
    logic [7:0]  s64_mem_be;

    logic        stall, rsp_valid, rsp_fault, mem_valid, mem_we;
    logic [63:0] rsp_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_be;

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    anu_lsu #(.XLEN(32), .TIMEOUT(16)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .stall(s32_stall), .rsp_valid(s32_rsp_valid), .rsp_rdata(s32_rsp_rdata),
        .rsp_fault(s32_rsp_fault), .mem_valid(s32_mem_valid), .mem_ready(mem_ready),
        .mem_we(s32_mem_we), .mem_addr(s32_mem_addr), .mem_be(s32_mem_be),
        .mem_wdata(s32_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    anu_lsu #(.XLEN(64), .TIMEOUT(4)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(s64_stall), .rsp_valid(s64_rsp_valid), .rsp_rdata(s64_rsp_rdata),
        .rsp_fault(s64_rsp_fault), .mem_valid(s64_mem_valid), .mem_ready(mem_ready),
        .mem_we(s64_mem_we), .mem_addr(s64_mem_addr), .mem_be(s64_mem_be),
        .mem_wdata(s64_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    assign stall     = sel ? s64_stall     : s32_stall;
    assign rsp_valid = sel ? s64_rsp_valid : s32_rsp_valid;
    assign rsp_fault = sel ? s64_rsp_fault : s32_rsp_fault;
    assign rsp_rdata = sel ? s64_rsp_rdata : {32'h0, s32_rsp_rdata};
    assign mem_valid = sel ? s64_mem_valid : s32_mem_valid;
    assign mem_we    = sel ? s64_mem_we    : s32_mem_we;
    assign mem_addr  = sel ? s64_mem_addr  : {32'h0, s32_mem_addr};
    assign mem_be    = sel ? s64_mem_be    : {4'h0, s32_mem_be};
    assign mem_wdata = sel ? s64_mem_wdata : {32'h0, s32_mem_wdata};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h fault %0b expected no response",
                         rsp_rdata, rsp_fault);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
            end
        end
    end

    // One request with a memory model: ready after rdy_dly REQ cycles,
    // rvalid after rv_dly RWAIT cycles; checks memory side, stall and latency.
    task automatic txn(input bit s, input bit we, input logic [1:0] size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input int rdy_dly, input int rv_dly, input logic [63:0] rdata,
                       input logic [63:0] e_addr, input logic [7:0] e_be,
                       input logic [63:0] e_wdata, input logic [63:0] e_rdata,
                       input bit e_fault, input int e_mv, input int e_cyc, input string name);
        int cyc, mv, rw;
        bit hs, done;
        logic [63:0] sa, sw;
        logic [7:0]  sb;
        logic        swe;
        @(negedge clk);
        sel = s; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = rdata;
        exp_q.push_back('{e_rdata, e_fault});
        #1 chk({name, "_stall0"}, 64'(stall), 64'd1);
        cyc = 0; mv = 0; rw = 0; hs = 1'b0; done = 1'b0;
        sa = '0; sw = '0; sb = '0; swe = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            if (mem_valid) begin
                if (mv == 0) begin
                    chk({name, "_addr"}, mem_addr, e_addr);
                    chk({name, "_be"}, 64'(mem_be), 64'(e_be));
                    chk({name, "_wdata"}, mem_wdata, e_wdata);
                    chk({name, "_we"}, 64'(mem_we), 64'(we));
                    sa = mem_addr; sb = mem_be; sw = mem_wdata; swe = mem_we;
                end else begin
                    chk({name, "_stable"}, 64'({mem_addr[31:0], mem_be, mem_we}) ^ (mem_wdata ^ sw),
                        64'({sa[31:0], sb, swe}));
                end
                mv++;
            end
            if (rsp_valid) begin
                chk({name, "_stall_end"}, 64'(stall), 64'd0);
                chk({name, "_latency"}, 64'(cyc), 64'(e_cyc));
                chk({name, "_mv_cycles"}, 64'(mv), 64'(e_mv));
                done = 1'b1;
                req_valid = 1'b0;
                mem_ready = 1'b0;
            end else begin
                chk({name, "_stall"}, 64'(stall), 64'd1);
                if (hs && !we) begin
                    mem_rvalid = (rw >= rv_dly);
                    rw++;
                end
                mem_ready = mem_valid && ((mv - 1) >= rdy_dly);
                hs = hs | (mem_valid & mem_ready);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no rsp_valid within 40 cycles expected one", name);
            req_valid = 1'b0;
            mem_ready = 1'b0;
            void'(exp_q.pop_back());
        end
        @(negedge clk);
        @(negedge clk);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_mem_valid", 64'({s32_mem_valid, s64_mem_valid}), 64'd0);
        chk("reset_rsp", 64'({s32_rsp_valid, s32_rsp_fault, s64_rsp_valid, s64_rsp_fault}), 64'd0);
        chk("reset_rdata", s64_rsp_rdata | 64'(s32_rsp_rdata), 64'd0);
        rst_n = 1'b1;

        txn(0, 1, 2'b00, 0, 64'h1003, 64'hAB, 0, 0, 64'h0,
            64'h1000, 8'h08, 64'hABABABAB, 64'h0, 0, 1, 2, "st_byte");
        txn(0, 0, 2'b01, 0, 64'h2002, 64'h0, 0, 0, 64'h80011234,
            64'h2000, 8'h0C, 64'h0, 64'hFFFF8001, 0, 1, 3, "ld_half_s");
        txn(0, 0, 2'b01, 1, 64'h2002, 64'h0, 0, 0, 64'h80011234,
            64'h2000, 8'h0C, 64'h0, 64'h00008001, 0, 1, 3, "ld_half_u");
        txn(0, 0, 2'b10, 0, 64'h4000, 64'h0, 5, 3, 64'hDEADBEEF,
            64'h4000, 8'h0F, 64'h0, 64'hDEADBEEF, 0, 6, 11, "backpressure");
`ifdef ANU_LSU_MISALIGN_EN
        txn(0, 0, 2'b10, 0, 64'h3002, 64'h0, 0, 0, 64'h11223344,
            64'h0, 8'h00, 64'h0, 64'h0, 1, 0, 1, "misalign_word");
`else
        txn(0, 0, 2'b10, 0, 64'h3002, 64'h0, 0, 0, 64'h11223344,
            64'h3000, 8'h0F, 64'h0, 64'h11223344, 0, 1, 3, "misalign_word");
`endif
        txn(0, 1, 2'b01, 0, 64'h5006, 64'h1234CDEF, 0, 0, 64'h0,
            64'h5004, 8'h0C, 64'hCDEFCDEF, 64'h0, 0, 1, 2, "st_half");
        txn(0, 0, 2'b00, 0, 64'h6001, 64'h0, 0, 0, 64'h12348056,
            64'h6000, 8'h02, 64'h0, 64'hFFFFFF80, 0, 1, 3, "ld_byte_s");

        // Reset while waiting for load data, then a stray rvalid in IDLE.
        @(negedge clk);
        sel = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'h7004; req_wdata = '0; req_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_txn_req", 64'(mem_valid), 64'd1);
        @(negedge clk);
        chk("rst_txn_rwait", 64'({mem_valid, rsp_valid}), 64'd0);
        rst_n = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'({mem_valid, mem_we, rsp_valid, rsp_fault, stall}), 64'd0);
        chk("rst_mid_addr", mem_addr, 64'd0);
        chk("rst_mid_be", 64'(mem_be), 64'd0);
        chk("rst_mid_data", mem_wdata | rsp_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_rvalid_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("stray_rvalid_idle", 64'({rsp_valid, mem_valid}), 64'd0);

        txn(1, 0, 2'b11, 0, 64'h8, 64'h0, 0, 0, 64'h8123456789ABCDEF,
            64'h8, 8'hFF, 64'h0, 64'h8123456789ABCDEF, 0, 1, 3, "ld_dbl64");
        txn(1, 0, 2'b10, 0, 64'hC, 64'h0, 0, 0, 64'h8000000100000000,
            64'h8, 8'hF0, 64'h0, 64'hFFFFFFFF80000001, 0, 1, 3, "ld_word64");
        txn(1, 1, 2'b10, 0, 64'h14, 64'hDEADBEEF, 0, 0, 64'h0,
            64'h10, 8'hF0, 64'hDEADBEEFDEADBEEF, 64'h0, 0, 1, 2, "st_word64");
        txn(1, 1, 2'b11, 0, 64'h20, 64'h0123456789ABCDEF, 1000, 0, 64'h0,
            64'h20, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 1, 4, 5, "timeout");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
